// File: rtl/npu_pkg.sv
// npu_pkg: shared types and constants for the NPU activation/accumulator datapath.
// Data and accumulator widths come from `DATA_WIDTH / `ACC_WIDTH (default 8 / 16).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

package npu_pkg;

    localparam int DATA_W = `DATA_WIDTH;
    localparam int ACC_W  = `ACC_WIDTH;

    // Default dequantizer configuration field widths; the block parameters
    // default to these so the config struct and the ports line up.
    localparam int DQ_SCALE_W = 8;
    localparam int DQ_SHIFT_W = 3;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef struct packed {
        data_t                 zero_point;
        logic [DQ_SCALE_W-1:0] scale;
        logic [DQ_SHIFT_W-1:0] shift;
    } dequant_cfg_t;

    localparam acc_t ACC_MAX = acc_t'({1'b0, {(ACC_W-1){1'b1}}});
    localparam acc_t ACC_MIN = acc_t'({1'b1, {(ACC_W-1){1'b0}}});

    // Identity transform: zero point 0, scale 1, no shift.
    localparam dequant_cfg_t DEQUANT_CFG_RST = '{
        zero_point: '0,
        scale:      DQ_SCALE_W'(1),
        shift:      '0
    };

endpackage

// File: rtl/sat_clip.sv
// sat_clip: clamps a wide signed value into the signed accumulator range and
// flags when clamping happened. Shared by the quantizer and dequantizer paths.
module sat_clip
    import npu_pkg::*;
#(
    parameter int IN_WIDTH = 24
) (
    input  logic signed [IN_WIDTH-1:0] din,
    output logic signed [ACC_W-1:0]    dout,
    output logic                       clip
);

    // Accumulator limits sign-extended to the input width for a signed compare.
    localparam logic signed [IN_WIDTH-1:0] WIDE_MAX = IN_WIDTH'(ACC_MAX);
    localparam logic signed [IN_WIDTH-1:0] WIDE_MIN = IN_WIDTH'(ACC_MIN);

    // Pass in-range values through unchanged, otherwise pin to the nearest limit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dout = din[ACC_W-1:0];
        clip = 1'b0;
        if (din > WIDE_MAX) begin
            dout = ACC_MAX;
            clip = 1'b1;
        end else if (din < WIDE_MIN) begin
            dout = ACC_MIN;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/dequantizer_stream.sv
// dequantizer_stream: two-stage valid/ready pipeline computing
//   out = sat_ACC(((in - zero_point) * scale) << shift)
// Stage 1 registers the zero-point-corrected difference plus a per-beat snapshot
// of scale/shift; stage 2 multiplies, shifts at full width and saturates.
// Optional: define DEQUANT_SAT_COUNT_EN to add the sat_count/sat_clr clip counter.
module dequantizer_stream
    import npu_pkg::*;
#(
    parameter int SCALE_WIDTH = DQ_SCALE_W,
    parameter int SHIFT_WIDTH = DQ_SHIFT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic signed [DATA_W-1:0] cfg_zero_point,
    input  logic [SCALE_WIDTH-1:0]   cfg_scale,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_sat
`ifdef DEQUANT_SAT_COUNT_EN
    ,
    output logic [15:0]              sat_count,
    input  logic                     sat_clr
`endif
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DIFF_W + SCALE_WIDTH;
    // Wide enough that the largest shift cannot overflow before saturation.
    localparam int WIDE_W = PROD_W + (1 << SHIFT_WIDTH) - 1;

    dequant_cfg_t cfg;

    logic s1_valid;
    logic s2_valid;
    logic s1_advance;
    logic in_fire;

    logic signed [DIFF_W-1:0] s1_diff;
    logic [SCALE_WIDTH-1:0]   s1_scale;
    logic [SHIFT_WIDTH-1:0]   s1_shift;

    logic signed [PROD_W-1:0] prod;
    logic signed [WIDE_W-1:0] shifted;
    logic signed [ACC_W-1:0]  clipped;
    logic                     clip;

    // Handshake: stage 1 moves when stage 2 is empty or draining this cycle.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = s2_valid;

    // Stage 2 arithmetic: scale is unsigned, so it is zero-extended before the signed multiply.
    assign prod    = PROD_W'(s1_diff) * PROD_W'($signed({1'b0, s1_scale}));
    assign shifted = WIDE_W'(prod) <<< s1_shift;

    sat_clip #(
        .IN_WIDTH (WIDE_W)
    ) u_sat_clip (
        .din  (shifted),
        .dout (clipped),
        .clip (clip)
    );

    // Live configuration register; a beat accepted on the same edge already captured the old value.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cfg <= DEQUANT_CFG_RST;
        end else if (cfg_we) begin
            cfg.zero_point <= cfg_zero_point;
            cfg.scale      <= cfg_scale;
            cfg.shift      <= cfg_shift;
        end
    end

    // Valid bits for both stages; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_advance) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Stage 1 payload: difference and per-beat config snapshot.
    always_ff @(posedge clk) begin
        // NOTE: payload flops carry no reset; their contents only matter while s1_valid is set.
        if (in_fire) begin
            s1_diff  <= DIFF_W'(in_data) - DIFF_W'(cfg.zero_point);
            s1_scale <= cfg.scale;
            s1_shift <= cfg.shift;
        end
    end

    // Stage 2 output register; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (s1_advance && s1_valid) begin
            out_data <= clipped;
            out_sat  <= clip;
        end
    end

`ifdef DEQUANT_SAT_COUNT_EN
    // Count clipped output transfers, sticking at all-ones; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_count <= '0;
        end else if (s2_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dequantizer_stream.md
Name: dequantizer_stream

Overview:
- Streaming inverse of the quantizer: expands signed `DATA_WIDTH` activations back to signed `ACC_WIDTH` accumulator-domain values.
- Computes out = sat_ACC(((in − zero_point) × scale) << shift).
- Sits between the activation buffer read port and the accumulator/residual-add path.
- Two-stage pipeline with valid/ready handshakes on both sides and a runtime-writable configuration.

Parameters:
- SCALE_WIDTH, 8, unsigned scale multiplier width.
- SHIFT_WIDTH, 3, width of the left-shift amount (shift range 0..2^SHIFT_WIDTH−1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_zero_point  in  `DATA_WIDTH`  signed zero point
- cfg_scale  in  SCALE_WIDTH  unsigned scale
- cfg_shift  in  SHIFT_WIDTH  left shift amount
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  `DATA_WIDTH`  signed quantized value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  `ACC_WIDTH`  signed dequantized value
- out_sat  out  1  this output beat was clipped

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset `rst` is synchronous, active-high.
  - On reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0, zero_point=0, scale=1, shift=0.
  - Reset mid-stream drops all in-flight beats with no output.
- Handshake:
  - A transfer occurs when valid & ready on the same edge.
  - out_valid/out_data/out_sat stay stable while out_valid & !out_ready.
  - in_ready is combinational: in_ready = !s1_valid | s1_advance.
  - s1_advance = !s2_valid | out_ready.
  - No combinational path from in_valid to out_valid.
- Stage 1, on input transfer:
  - Registers diff = in_data − zero_point, sign-extended to `DATA_WIDTH`+1 bits (range −255..255 for 8-bit).
  - Also registers scale and shift, snapshotted per beat.
- Stage 2, on s1_advance with s1_valid:
  - prod = diff × scale, signed width `DATA_WIDTH`+1+SCALE_WIDTH.
  - shifted = prod << shift, computed at full width (no overflow before the compare).
  - Saturates to [−2^(ACC−1), 2^(ACC−1)−1].
  - out_sat = 1 when a clip occurred.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_valid with out_ready held high.
  - Full throughput: 1 beat/cycle.
  - out_ready low for N cycles: the pipeline holds 2 beats, then in_ready drops; no beat is lost or duplicated.
- Configuration:
  - cfg_we updates the live config registers at the edge.
  - A beat accepted in the same cycle as cfg_we uses the OLD config; later beats use the new config.
  - Beats already in flight are unaffected.
- Boundaries:
  - diff = 0 gives out = 0 regardless of scale/shift.
  - scale = 0 gives out = 0, out_sat = 0.
  - Maximum-negative and maximum-positive clips are symmetric per the ranges above.

Optional Feature:
- Macro: `DEQUANT_SAT_COUNT_EN`.
- When defined, adds these ports:
  - sat_count  out  16  counts output transfers with out_sat=1; saturates at 0xFFFF and does not wrap.
  - sat_clr  in  1  synchronous clear; clr wins over increment in the same cycle.
- sat_count resets to 0 on rst.
- When undefined: ports absent, no counter logic; all other behaviour identical.

Decomposition:
- Shared package `npu_pkg`:
  - typedefs data_t (`DATA_WIDTH`), acc_t (`ACC_WIDTH`).
  - dequant_cfg_t struct (zero_point, scale, shift).
  - localparams ACC_MAX, ACC_MIN.
- One natural sub-module, `sat_clip`: combinational wide-signed to `ACC_WIDTH` saturation with clip flag. It is reusable by the quantizer path.

Test Plan (bench uses the 8-bit data / 16-bit accumulator build):
- After reset, cfg zp=3, scale=4, shift=0; in=5 -> out_data=8, out_sat=0, two cycles after acceptance.
- zp=−128, scale=255, shift=0, in=127 -> diff=255, prod=65025 -> out=32767, out_sat=1. Then in=−128, zp=127, scale=255 -> out=−32768, out_sat=1.
- Back-to-back beats 1..10 with zp=0, scale=1, shift=2 -> outputs 4,8,…,40 in order, one per cycle.
- Random out_ready stall pattern over 100 beats -> scoreboard matches, in_ready low only while both stages are full, held outputs stable.
- cfg_we (scale 2 -> 3) asserted in the same cycle as accepting in=10, zp=0; next beat in=10 -> outputs 20 then 30.
- Reset asserted with 2 beats in flight -> out_valid=0 next cycle, no stale beat emitted. With `DEQUANT_SAT_COUNT_EN`: 3 clipped beats -> sat_count=3; sat_clr -> 0.
